// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Sequences each frame through Tx_WR / Tx_BUSY with a busy-start timeout and inter-frame gap.
//
// state        | meaning
// S_IDLE       | waiting for arb_en, a request and a quiet transmitter
// S_WRITE      | byte latched, ack pulsing; Tx_WR strobe issued on exit
// S_WAIT_START | waiting for Tx_BUSY to rise (bounded by BUSY_TIMEOUT)
// S_WAIT_DONE  | transmitter busy with the frame
// S_GAP        | inter-frame idle time before the next grant
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [7:0]                 Tx_DATA,
    output logic                       Tx_WR,
    output logic                       Tx_EN,
    input  logic                       Tx_BUSY,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       timeout_err
);

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);
    // A zero gap still spends one cycle in S_GAP.
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_wr_q, tx_wr_d;
    logic               tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               active_q, active_d;
    logic               timeout_err_q, timeout_err_d;

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     cand;
    logic [7:0]         win_data;
    logic               grant;
    logic               start_timeout;
    logic               gap_done;

    // Search starts just after the last winner so every pending requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k >= NUM_REQ) ? IDW'(int'(ptr_q) + k - NUM_REQ)
                                                : IDW'(int'(ptr_q) + k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    assign grant         = (state_q == S_IDLE) && arb_en && win_found && !Tx_BUSY;
    assign start_timeout = (state_q == S_WAIT_START) && !Tx_BUSY && (cnt_q == TO_LAST);
    assign gap_done      = (state_q == S_GAP) && (cnt_q == GAP_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (Tx_BUSY) begin
                    state_d = S_WAIT_DONE;
                end else if (start_timeout) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!Tx_BUSY) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        tx_en_d       = tx_en_q;
        active_d      = active_q;
        timeout_err_d = timeout_err_q;
        req_ack_d     = '0;
        tx_wr_d       = 1'b0;
        if (grant) begin
            tx_data_d  = win_data;
            grant_id_d = win_id;
            ptr_d      = win_id;
            req_ack_d  = NUM_REQ'(1) << win_id;
            tx_en_d    = 1'b1;
            active_d   = 1'b1;
        end
        if (state_q == S_WRITE) begin
            tx_wr_d = 1'b1;
        end
        if (start_timeout) begin
            timeout_err_d = 1'b1;
        end
        if (gap_done) begin
            tx_en_d  = 1'b0;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_data_q     <= '0;
            tx_wr_q       <= 1'b0;
            tx_en_q       <= 1'b0;
            req_ack_q     <= '0;
            grant_id_q    <= '0;
            ptr_q         <= IDW'(NUM_REQ - 1);
            active_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_data_q     <= tx_data_d;
            tx_wr_q       <= tx_wr_d;
            tx_en_q       <= tx_en_d;
            req_ack_q     <= req_ack_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            active_q      <= active_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign Tx_DATA     = tx_data_q;
    assign Tx_WR       = tx_wr_q;
    assign Tx_EN       = tx_en_q;
    assign req_ack     = req_ack_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a queue-free round-robin model
// and a simple transmitter model answering Tx_WR with a Tx_BUSY pulse.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int G     = 3;
    localparam int TO    = 8;
    localparam int LIMIT = 400;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          arb_en = 1'b0;
    logic [NR-1:0] req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_ack;
    logic [7:0]    Tx_DATA;
    logic          Tx_WR;
    logic          Tx_EN;
    logic          Tx_BUSY;
    logic [1:0]    grant_id;
    logic          active;
    logic          timeout_err;

    logic busy_man = 1'b0;
    logic busy_auto = 1'b0;
    logic busy_auto_q = 1'b0;
    int   busy_delay = 2;
    int   busy_len = 5;

    int n_pass = 0;
    int n_total = 0;
    int ack_cnt = 0;
    int wr_cnt = 0;
    int exp_frames = 0;
    int m_ptr = NR - 1;

    assign Tx_BUSY = busy_man | busy_auto_q;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .GAP_CYCLES(G),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .arb_en(arb_en),
        .req(req),
        .req_data(req_data),
        .req_ack(req_ack),
        .Tx_DATA(Tx_DATA),
        .Tx_WR(Tx_WR),
        .Tx_EN(Tx_EN),
        .Tx_BUSY(Tx_BUSY),
        .grant_id(grant_id),
        .active(active),
        .timeout_err(timeout_err)
    );

    always @(negedge clock) begin
        if (req_ack != '0) ack_cnt++;
        if (Tx_WR) wr_cnt++;
    end

    // Transmitter model: busy rises busy_delay clocks after the strobe, lasts busy_len clocks.
    initial begin
        forever begin
            @(negedge clock);
            if (busy_auto && Tx_WR) begin
                repeat (busy_delay) @(negedge clock);
                busy_auto_q = 1'b1;
                repeat (busy_len) @(negedge clock);
                busy_auto_q = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
        int j;
        for (int k = 1; k <= NR; k++) begin
            j = (ptr + k) % NR;
            if (r[j[1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic run_frame(input string tag, input logic [NR-1:0] req_after,
                             input int exp_wait, input bit manual_busy);
        int t;
        int exp_id;
        logic [7:0] exp_data;
        t = 0;
        exp_id = rr_pick(m_ptr, req);
        exp_data = 8'(req_data >> (8 * exp_id));
        while (req_ack == '0 && t < LIMIT) begin
            @(negedge clock);
            t++;
        end
        check({tag, " ack_seen"}, 32'(t < LIMIT), 1);
        if (exp_wait >= 0) check({tag, " latency"}, t, exp_wait);
        check({tag, " ack"}, 32'(req_ack), 32'(4'(1) << exp_id));
        check({tag, " data"}, 32'(Tx_DATA), 32'(exp_data));
        check({tag, " grant_id"}, 32'(grant_id), exp_id);
        check({tag, " en"}, 32'({Tx_EN, active, Tx_WR}), 32'b110);
        m_ptr = exp_id;
        exp_frames++;
        req = req_after;
        @(negedge clock);
        check({tag, " wr"}, 32'({Tx_WR, req_ack}), 32'b10000);
        if (manual_busy) begin
            @(negedge clock);
            busy_man = 1'b1;
            repeat (6) @(negedge clock);
            busy_man = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (active !== 1'b0 && t < LIMIT) begin
            @(negedge clock);
            t++;
        end
        check({tag, " idle"}, 32'(t < LIMIT), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " outs"}, {Tx_DATA, req_ack, grant_id, Tx_WR, Tx_EN, active, timeout_err}, 0);
    endtask

    initial begin
        int rr_order[5];
        int fair_order[4];
        int base;
        int exp;
        logic [NR-1:0] nr;
        logic [NR-1:0] old_req;
        rr_order = '{0, 1, 2, 3, 0};
        fair_order = '{3, 0, 3, 0};

        arb_en = 1'b1;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clock);
        check_zero("post_reset");

        // single request with manual busy timing
        req_data = 32'h00A5_0000;
        req = 4'b0100;
        run_frame("single", 4'b0000, 1, 1'b0);
        @(negedge clock);
        busy_man = 1'b1;
        repeat (100) @(negedge clock);
        check("single busy_hold", 32'({active, Tx_WR}), 32'b10);
        busy_man = 1'b0;
        repeat (G) @(negedge clock);
        check("single gap_active", 32'(active), 1);
        @(negedge clock);
        check("single idle", 32'({active, Tx_EN, Tx_DATA}), 32'h0A5);

        reset = 1'b0;
        m_ptr = NR - 1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // round robin with all requesters held
        req_data = 32'h1312_1110;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("rr%0d", i), (i == 4) ? 4'b0000 : 4'b1111,
                      (i == 0) ? 1 : G + 2, 1'b1);
            check($sformatf("rr%0d order", i), 32'(grant_id), rr_order[i]);
        end
        wait_idle("rr");

        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("fair%0d", i), (i == 3) ? 4'b0000 : 4'b1001,
                      (i == 0) ? 1 : G + 2, 1'b1);
            check($sformatf("fair%0d order", i), 32'(grant_id), fair_order[i]);
        end
        wait_idle("fair");

        // busy never rises
        req_data = 32'($urandom);
        req = 4'b0010;
        run_frame("to", 4'b0000, 1, 1'b0);
        repeat (TO - 1) @(negedge clock);
        check("to before", 32'({timeout_err, active}), 32'b01);
        @(negedge clock);
        check("to set", 32'(timeout_err), 1);
        repeat (G - 1) @(negedge clock);
        check("to gap", 32'(active), 1);
        @(negedge clock);
        check("to idle", 32'({active, Tx_EN}), 0);
        req = 4'b1000;
        run_frame("to_next", 4'b0000, 1, 1'b1);
        check("to sticky", 32'(timeout_err), 1);
        wait_idle("to");

        // arb_en drop mid-frame, then busy gating
        req_data = 32'($urandom);
        req = 4'b0001;
        run_frame("arb", 4'b0001, 1, 1'b0);
        @(negedge clock);
        busy_man = 1'b1;
        repeat (2) @(negedge clock);
        arb_en = 1'b0;
        repeat (4) @(negedge clock);
        base = ack_cnt;
        busy_man = 1'b0;
        repeat (30) @(negedge clock);
        check("arb_off acks", ack_cnt - base, 0);
        check("arb_off active", 32'(active), 0);
        busy_man = 1'b1;
        arb_en = 1'b1;
        repeat (10) @(negedge clock);
        check("busy_gate acks", ack_cnt - base, 0);
        busy_man = 1'b0;
        run_frame("arb_on", 4'b0000, 1, 1'b1);
        wait_idle("arb");

        // async reset inside WAIT_DONE
        req = 4'b0100;
        run_frame("rst_pre", 4'b0000, 1, 1'b0);
        @(negedge clock);
        busy_man = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero("rst_async");
        m_ptr = NR - 1;
        @(negedge clock);
        reset = 1'b1;
        busy_man = 1'b0;
        req_data = 32'($urandom);
        req = 4'b1111;
        run_frame("rst_post", 4'b0000, 1, 1'b1);
        check("rst_post winner", 32'(grant_id), 0);
        wait_idle("rst");

        // randomized traffic against the round-robin model
        busy_auto = 1'b1;
        req_data = 32'($urandom);
        req = 4'($urandom_range(1, 15));
        for (int n = 0; n < 40; n++) begin
            busy_delay = $urandom_range(1, 5);
            busy_len = $urandom_range(1, 20);
            exp = rr_pick(m_ptr, req);
            old_req = req;
            nr = req;
            if ($urandom_range(0, 1) == 1) nr[exp[1:0]] = 1'b0;
            nr = nr | (4'($urandom) & 4'($urandom));
            if (nr == '0) nr = 4'(1) << $urandom_range(0, 3);
            if (n == 39) nr = '0;
            run_frame($sformatf("rand%0d", n), nr, -1, 1'b0);
            for (int i = 0; i < NR; i++) begin
                if (i == exp || !old_req[i]) begin
                    req_data = (req_data & ~(32'hFF << (8 * i)))
                             | (32'($urandom_range(0, 255)) << (8 * i));
                end
            end
        end
        wait_idle("rand");

        repeat (3) @(negedge clock);
        check("ack pulses", ack_cnt, exp_frames);
        check("wr pulses", wr_cnt, exp_frames);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
